mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between the processor's instruction-fetch port (IF) and its
//  load/store port (D). Used when the split instruction/data memories are merged into one.
//  One access is outstanding at a time, with a valid/grant request side and an ack-terminated
//  memory side. A timeout watchdog aborts accesses that are never acknowledged.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width
//  TIMEOUT  255  max cycles in WAIT before abort; 0 disables watchdog
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous reset, active-low (asserted when 0)
//  if_req     in   1   fetch request; held until if_gnt
//  if_addr    in   AW  fetch address; stable while if_req=1
//  if_gnt     out  1   1-cycle pulse: fetch request accepted
//  if_rvalid  out  1   1-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DW  fetch read data
//  if_err     out  1   1-cycle pulse: fetch aborted by timeout
//  d_req      in   1   data request; held until d_gnt
//  d_we       in   1   1=store, 0=load
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_gnt      out  1   1-cycle pulse: data request accepted
//  d_rvalid   out  1   1-cycle pulse: load/store complete
//  d_rdata    out  DW  load data; 0 for stores
//  d_err      out  1   1-cycle pulse: data access aborted by timeout
//  mem_req    out  1   memory request; held until mem_ack or abort
//  mem_we     out  1   memory write enable (latched)
//  mem_addr   out  AW  memory address (latched)
//  mem_wdata  out  DW  memory write data (latched)
//  mem_ack    in   1   memory completion, 1 cycle; ignored unless mem_req=1
//  mem_rdata  in   DW  memory read data, valid with mem_ack
//  busy       out  1   1 while in WAIT
// BEHAVIOUR
//  - Reset (reset=0 at posedge): state=IDLE; all outputs 0; latches cleared; owner=D;
//    last_grant=D; timer=0. Reset mid-WAIT drops mem_req next cycle, with no rvalid/err.
//  - IDLE: if any req, pick winner, assert its gnt (combinational, same cycle), latch
//    we/addr/wdata/owner (IF forces we=0, wdata=0), clear timer, -> WAIT.
//  - WAIT: mem_req=1 with latched fields; timer increments each cycle.
//    - mem_ack=1: owner rvalid=1 (registered, next cycle), rdata=mem_rdata (stores: 0) -> IDLE.
//    - else TIMEOUT!=0 && timer==TIMEOUT-1: owner err=1 next cycle, mem_req drops -> IDLE.
//    - Ack and timeout in the same cycle: ack wins.
//  - No grant in WAIT; new requests wait. Earliest re-grant is the cycle rvalid/err pulses.
//    Throughput: 1 access per (memory latency + 1) cycles.
//  - The non-owner's rvalid/err/rdata stay 0.
//  - Timer is 8 bits wide minimum, sized $clog2(TIMEOUT+1); saturates, never wraps.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the port not in last_grant wins.
//    last_grant updates on every gnt.
//  MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, D always beats IF. last_grant is not
//    implemented.
// STRUCTURE
//  mem_arb_pkg: state encoding (ST_IDLE, ST_WAIT), port ids (PORT_IF=0, PORT_D=1),
//    TIMER_W helper function.
//  Sub-module arb_timeout_counter: clear/enable/saturating count with a done flag at TIMEOUT-1.
//  FSM, latches and response routing stay in the top module.
// TESTING
//  1. Reset held 3 cycles with if_req=d_req=1 -> no gnt; mem_req=0; all outputs 0.
//  2. IF only, addr=0x100, mem acks after 2 cycles with 0xDEADBEEF:
//     if_gnt@t0, mem_req@t1..t2, if_rvalid@t3 with if_rdata=0xDEADBEEF.
//  3. D store addr=0x40, wdata=0x12345678: mem_we=1, mem_wdata=0x12345678,
//     d_rvalid with d_rdata=0.
//  4. Both req every cycle, ack latency 1: fixed -> 4 grants all D (IF starves);
//     RR -> IF,D,IF,D (first IF since last_grant=D after reset).
//  5. TIMEOUT=4, D load, never ack -> mem_req high 4 cycles, d_err pulse,
//     no d_rvalid; next IF request granted the following cycle.
//  6. reset=0 in 2nd WAIT cycle, then mem_ack -> mem_req=0; ack ignored; no rvalid/err.
//     IF request after release served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the unified memory port arbiter: FSM state encoding, requester port
//   identifiers and the watchdog timer width helper.
// ---------------------------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Timer is wide enough to hold TIMEOUT, and never narrower than 8 bits.
    function automatic int unsigned timer_w(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        if (w < 8) begin
            w = 8;
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// ---------------------------------------------------------------------------------------------
// arb_timeout_counter
//   Saturating watchdog counter for the arbiter's WAIT state. Clear has priority over enable.
//   o_done flags the last permitted WAIT cycle (count == TIMEOUT-1); it never asserts when
//   TIMEOUT is 0, which disables the watchdog.
// Ports
//   clk      in   clock
//   reset    in   synchronous reset, active-low
//   i_clr    in   clear count to 0
//   i_en     in   count up by one (saturates at all-ones)
//   o_done   out  count has reached TIMEOUT-1
// ---------------------------------------------------------------------------------------------
module arb_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    localparam int unsigned W       = timer_w(TIMEOUT);
    localparam bit          WdogEn  = (TIMEOUT != 0);
    localparam int unsigned LastCnt = WdogEn ? TIMEOUT - 1 : 0;

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = WdogEn && (r_count == W'(LastCnt));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between the instruction-fetch (IF) and load/store (D) requesters.
//   One access outstanding at a time; grants are combinational in IDLE, responses are
//   registered one cycle after mem_ack. A watchdog aborts unacknowledged accesses.
//   Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin on simultaneous requests;
//   otherwise D has fixed priority over IF.
// Ports
//   clk, reset                   clock; synchronous active-low reset
//   if_req/if_addr               fetch request side
//   if_gnt/if_rvalid/if_rdata/if_err   fetch response pulses
//   d_req/d_we/d_addr/d_wdata    load/store request side
//   d_gnt/d_rvalid/d_rdata/d_err       load/store response pulses
//   mem_req/mem_we/mem_addr/mem_wdata  memory request (held through WAIT)
//   mem_ack/mem_rdata            memory completion
//   busy                         access in flight (WAIT)
// ---------------------------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_e        r_state;
    state_e        w_state_next;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_if_rvalid;
    logic [DW-1:0] r_if_rdata;
    logic          r_if_err;
    logic          r_d_rvalid;
    logic [DW-1:0] r_d_rdata;
    logic          r_d_err;

    logic          w_any;
    logic          w_winner;
    logic          w_grant;
    logic          w_ack;
    logic          w_abort;
    logic          w_done;

    // Gate with reset so no grant escapes while reset is held.
    assign w_any = reset && (if_req || d_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    always_comb begin
        if (if_req && d_req) begin
            w_winner = (r_last_grant == PORT_D) ? PORT_IF : PORT_D;
        end else begin
            w_winner = d_req ? PORT_D : PORT_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant <= PORT_D;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
        end
    end
`else
    assign w_winner = d_req ? PORT_D : PORT_IF;
`endif

    // FSM next-state and decoded strobes
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_ack        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Ack wins over a coincident timeout.
                if (mem_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_done) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latches; IF accesses are always reads with zero write data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner <= PORT_D;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_winner;
            r_we    <= (w_winner == PORT_D) ? d_we : 1'b0;
            r_addr  <= (w_winner == PORT_D) ? d_addr : if_addr;
            r_wdata <= (w_winner == PORT_D) ? d_wdata : '0;
        end
    end

    // Response routing: pulses go to the owner only, data is zero outside the pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_err     <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_err     <= 1'b0;
            if (w_ack) begin
                if (r_owner == PORT_IF) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= mem_rdata;
                end else begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= r_we ? '0 : mem_rdata;
                end
            end else if (w_abort) begin
                if (r_owner == PORT_IF) begin
                    r_if_err <= 1'b1;
                end else begin
                    r_d_err <= 1'b1;
                end
            end
        end
    end

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_grant),
        .i_en   (r_state == ST_WAIT),
        .o_done (w_done)
    );

    assign if_gnt    = w_grant && (w_winner == PORT_IF);
    assign d_gnt     = w_grant && (w_winner == PORT_D);
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_req   = (r_state == ST_WAIT);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter (TIMEOUT=4). Inputs are driven 1 time
//   unit after each rising edge and outputs sampled 1 time unit later.
// ---------------------------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_d;

        // 1. Reset held with both requests active
        reset     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0010;
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h0000_0020;
        d_wdata   = 32'h0000_0030;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            check_eq($sformatf("rst_if_gnt%0d", i), if_gnt, 0);
            check_eq($sformatf("rst_d_gnt%0d", i), d_gnt, 0);
            check_eq($sformatf("rst_mem_req%0d", i), mem_req, 0);
            check_eq($sformatf("rst_busy%0d", i), busy, 0);
        end
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_if_rvalid", if_rvalid, 0);
        check_eq("rst_if_rdata", if_rdata, 0);
        check_eq("rst_if_err", if_err, 0);
        check_eq("rst_d_rvalid", d_rvalid, 0);
        check_eq("rst_d_rdata", d_rdata, 0);
        check_eq("rst_d_err", d_err, 0);
        tick();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        reset  = 1'b1;
        settle();
        check_eq("rel_mem_req", mem_req, 0);

        // 2. IF read, ack two cycles after grant
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        settle();
        check_eq("t2_if_gnt", if_gnt, 1);
        check_eq("t2_d_gnt", d_gnt, 0);
        check_eq("t2_mem_req_t0", mem_req, 0);
        tick();
        if_req = 1'b0;
        settle();
        check_eq("t2_mem_req_t1", mem_req, 1);
        check_eq("t2_mem_addr", mem_addr, 32'h0000_0100);
        check_eq("t2_mem_we", mem_we, 0);
        check_eq("t2_busy", busy, 1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        check_eq("t2_mem_req_t2", mem_req, 1);
        tick();
        mem_ack = 1'b0;
        settle();
        check_eq("t2_if_rvalid", if_rvalid, 1);
        check_eq("t2_if_rdata", if_rdata, 32'hDEAD_BEEF);
        check_eq("t2_d_rvalid", d_rvalid, 0);
        check_eq("t2_mem_req_t3", mem_req, 0);
        tick();
        settle();
        check_eq("t2_if_rvalid_t4", if_rvalid, 0);
        check_eq("t2_if_rdata_t4", if_rdata, 0);

        // 3. D store
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0040;
        d_wdata = 32'h1234_5678;
        settle();
        check_eq("t3_d_gnt", d_gnt, 1);
        check_eq("t3_if_gnt", if_gnt, 0);
        tick();
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        settle();
        check_eq("t3_mem_req", mem_req, 1);
        check_eq("t3_mem_we", mem_we, 1);
        check_eq("t3_mem_wdata", mem_wdata, 32'h1234_5678);
        check_eq("t3_mem_addr", mem_addr, 32'h0000_0040);
        tick();
        mem_ack = 1'b0;
        settle();
        check_eq("t3_d_rvalid", d_rvalid, 1);
        check_eq("t3_d_rdata", d_rdata, 0);
        check_eq("t3_if_rvalid", if_rvalid, 0);
        check_eq("t3_mem_req_done", mem_req, 0);

        // Reset pulse so arbitration history starts from last_grant=D
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // 4. Both request continuously, ack latency 1
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0300;
        settle();
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (g % 2) == 1;
`else
            exp_d = 1'b1;
`endif
            check_eq($sformatf("t4_d_gnt%0d", g), d_gnt, exp_d);
            check_eq($sformatf("t4_if_gnt%0d", g), if_gnt, !exp_d);
            tick();
            mem_ack   = 1'b1;
            mem_rdata = 32'h0000_1000 + g;
            settle();
            check_eq($sformatf("t4_mem_req%0d", g), mem_req, 1);
            check_eq($sformatf("t4_mem_addr%0d", g), mem_addr,
                     exp_d ? 32'h0000_0300 : 32'h0000_0200);
            tick();
            mem_ack = 1'b0;
            if (g == 3) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            settle();
            check_eq($sformatf("t4_d_rvalid%0d", g), d_rvalid, exp_d);
            check_eq($sformatf("t4_if_rvalid%0d", g), if_rvalid, !exp_d);
        end

        // 5. D load never acknowledged -> timeout after 4 WAIT cycles
        tick();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0080;
        settle();
        check_eq("t5_d_gnt", d_gnt, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            d_req = 1'b0;
            settle();
            check_eq($sformatf("t5_mem_req%0d", k), mem_req, 1);
            check_eq($sformatf("t5_d_err_early%0d", k), d_err, 0);
        end
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0104;
        settle();
        check_eq("t5_mem_req_drop", mem_req, 0);
        check_eq("t5_d_err", d_err, 1);
        check_eq("t5_d_rvalid", d_rvalid, 0);
        check_eq("t5_if_err", if_err, 0);
        check_eq("t5_if_gnt", if_gnt, 1);
        tick();
        if_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        settle();
        check_eq("t5_mem_req_if", mem_req, 1);
        check_eq("t5_d_err_gone", d_err, 0);
        check_eq("t5_mem_addr_if", mem_addr, 32'h0000_0104);
        tick();
        mem_ack = 1'b0;
        settle();
        check_eq("t5_if_rvalid", if_rvalid, 1);
        check_eq("t5_if_rdata", if_rdata, 32'h5A5A_5A5A);
        check_eq("t5_d_rvalid_if", d_rvalid, 0);

        // 6. Reset during WAIT, then a stray ack
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        settle();
        check_eq("t6_if_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0;
        settle();
        check_eq("t6_mem_req_w1", mem_req, 1);
        tick();
        reset = 1'b0;
        settle();
        check_eq("t6_mem_req_w2", mem_req, 1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        settle();
        check_eq("t6_mem_req_rst", mem_req, 0);
        check_eq("t6_busy_rst", busy, 0);
        tick();
        mem_ack = 1'b0;
        reset   = 1'b1;
        settle();
        check_eq("t6_if_rvalid", if_rvalid, 0);
        check_eq("t6_if_err", if_err, 0);
        check_eq("t6_d_rvalid", d_rvalid, 0);
        check_eq("t6_mem_req", mem_req, 0);
        tick();
        mem_ack = 1'b1;
        settle();
        tick();
        mem_ack = 1'b0;
        settle();
        check_eq("t6_stray_rvalid", if_rvalid, 0);
        check_eq("t6_stray_mem_req", mem_req, 0);
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        settle();
        check_eq("t6_if_gnt2", if_gnt, 1);
        tick();
        if_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1122_3344;
        settle();
        check_eq("t6_mem_req2", mem_req, 1);
        check_eq("t6_mem_addr2", mem_addr, 32'h0000_0300);
        tick();
        mem_ack = 1'b0;
        settle();
        check_eq("t6_if_rvalid2", if_rvalid, 1);
        check_eq("t6_if_rdata2", if_rdata, 32'h1122_3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
